// File: rtl/data_memory_pkg.sv
// data_memory_pkg: Hack data-memory address map, depths and screen-port arbiter encodings.
package data_memory_pkg;
  localparam int RAM_DEPTH = 16384;
  localparam int SCREEN_DEPTH = 8192;
  localparam logic [15:0] RAM_BASE = 16'h0000;
  localparam logic [15:0] SCREEN_BASE = 16'h4000;
  localparam logic [15:0] KBD_ADDR = 16'h6000;
  typedef enum logic {IDLE, CPU_LOCK} arb_state_e;
  typedef enum logic [1:0] {SRC_NONE, SRC_RAM, SRC_SCR, SRC_KBD} rd_src_e;
endpackage

// File: rtl/data_memory_word_ram.sv
// word_ram: single-port 16-bit RAM, one-cycle synchronous read returning old data on write.
module word_ram #(
  parameter int DEPTH = 16384,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [15:0]   wdata_i,
  output logic [15:0]   rdata_o
);
  logic [15:0] mem_q [DEPTH];
  logic [15:0] rdata_q;
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_q <= mem_q[addr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/data_memory.sv
// data_memory: Hack data-memory decode, screen-port arbitration between CPU and video, registered read paths.
module data_memory
  import data_memory_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] mem_address,
  input  logic        mem_write,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_busy,
  input  logic [15:0] kbd_code,
  input  logic        vid_req,
  input  logic [12:0] vid_addr,
  output logic        vid_ack,
  output logic [15:0] vid_rdata,
  output logic        vid_valid
);
  logic ram_sel, scr_sel, kbd_sel, vid_own, ram_we, scr_we;
  logic rd_q, vpend_q, vid_valid_q;
  logic [12:0] scr_addr;
  logic [15:0] ram_rdata, scr_rdata, kbd_q, mem_rdata_q, vid_rdata_q;
  arb_state_e state_q, state_d;
  rd_src_e src_q, src_d;

  assign ram_sel = mem_address[15:14] == RAM_BASE[15:14];
  assign scr_sel = mem_address[15:13] == SCREEN_BASE[15:13];
  assign kbd_sel = mem_address == KBD_ADDR;
  // Video wins any IDLE cycle; a CPU screen access always earns the following cycle.
  assign vid_own = state_q == IDLE && vid_req;
  assign vid_ack = vid_own;
  assign mem_busy = scr_sel && vid_own;
  assign state_d = (state_q == IDLE && scr_sel) ? CPU_LOCK : IDLE;
  assign src_d = ram_sel ? SRC_RAM : scr_sel ? SRC_SCR : kbd_sel ? SRC_KBD : SRC_NONE;
  assign ram_we = reset_n && mem_write && ram_sel;
  assign scr_we = reset_n && mem_write && scr_sel && !vid_own;
  assign scr_addr = vid_own ? vid_addr : mem_address[12:0];

  word_ram #(.DEPTH(RAM_DEPTH)) u_ram (
    .clk(clk), .we_i(ram_we), .addr_i(mem_address[13:0]), .wdata_i(mem_wdata), .rdata_o(ram_rdata)
  );
  word_ram #(.DEPTH(SCREEN_DEPTH)) u_scr (
    .clk(clk), .we_i(scr_we), .addr_i(scr_addr), .wdata_i(mem_wdata), .rdata_o(scr_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      src_q <= SRC_NONE;
      rd_q <= 1'b0;
      kbd_q <= '0;
      vpend_q <= 1'b0;
      vid_valid_q <= 1'b0;
      mem_rdata_q <= '0;
      vid_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      src_q <= src_d;
      rd_q <= !mem_busy;
      kbd_q <= kbd_code;
      vpend_q <= vid_own;
      vid_valid_q <= vpend_q;
      if (vpend_q) vid_rdata_q <= scr_rdata;
      if (rd_q) mem_rdata_q <= src_q == SRC_RAM ? ram_rdata : src_q == SRC_SCR ? scr_rdata :
                               src_q == SRC_KBD ? kbd_q : '0;
    end
  end

  assign mem_rdata = mem_rdata_q;
  assign vid_rdata = vid_rdata_q;
  assign vid_valid = vid_valid_q;
endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed scenarios plus a randomized run scored against a behavioural memory model.
module tb_data_memory;
  logic clk = 1'b0;
  logic reset_n;
  logic [15:0] mem_address, mem_wdata, kbd_code, mem_rdata, vid_rdata;
  logic mem_write, vid_req, mem_busy, vid_ack, vid_valid;
  logic [12:0] vid_addr;
  int cmps = 0;
  int errs = 0;
  logic [15:0] ram_m [16384];
  logic [15:0] scr_m [8192];

  always #5 clk = ~clk;

  data_memory dut (
    .clk(clk), .reset_n(reset_n), .mem_address(mem_address), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_busy(mem_busy), .kbd_code(kbd_code),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .vid_valid(vid_valid)
  );

  task automatic nxt; @(posedge clk); #1; endtask
  task automatic smp; @(negedge clk); endtask
  task automatic cpu(input logic [15:0] a, input logic w, input logic [15:0] d);
    mem_address = a; mem_write = w; mem_wdata = d;
  endtask

  function automatic logic [15:0] model_rd(input logic [15:0] a, input logic [15:0] k);
    if (a < 16'h4000) return ram_m[a[13:0]];
    if (a < 16'h6000) return scr_m[a[12:0]];
    return (a == 16'h6000) ? k : 16'h0000;
  endfunction

  task automatic test_reset;
    reset_n = 1'b0; cpu(16'h4003, 1'b0, 16'h0); vid_req = 1'b1; vid_addr = '0; kbd_code = '0;
    repeat (2) nxt;
    smp;
    cmps++; if (mem_rdata !== 16'h0) begin errs++; $display("FAIL rst_mem_rdata got %h want 0000", mem_rdata); end
    cmps++; if (vid_rdata !== 16'h0) begin errs++; $display("FAIL rst_vid_rdata got %h want 0000", vid_rdata); end
    cmps++; if (vid_valid !== 1'b0) begin errs++; $display("FAIL rst_vid_valid got %b want 0", vid_valid); end
    cmps++; if (vid_ack !== 1'b1) begin errs++; $display("FAIL rst_vid_ack got %b want 1", vid_ack); end
    cmps++; if (mem_busy !== 1'b1) begin errs++; $display("FAIL rst_mem_busy got %b want 1", mem_busy); end
    nxt; cpu(16'h0000, 1'b0, 16'h0); vid_req = 1'b0;
    smp;
    cmps++; if (vid_ack !== 1'b0 || mem_busy !== 1'b0) begin errs++; $display("FAIL rst_idle_decode got ack=%b busy=%b want 0/0", vid_ack, mem_busy); end
    reset_n = 1'b1;
  endtask

  task automatic init_mem;
    for (int i = 0; i < 64; i++) begin nxt; ram_m[i] = 16'($urandom); cpu(i[15:0], 1'b1, ram_m[i]); end
    for (int i = 0; i < 32; i++) begin nxt; scr_m[i] = 16'($urandom); cpu(16'h4000 + i[15:0], 1'b1, scr_m[i]); end
    nxt; cpu(16'h0000, 1'b0, 16'h0);
  endtask

  task automatic test_ram;
    logic [15:0] old = ram_m[16];
    nxt; cpu(16'h0010, 1'b1, 16'h1234);
    smp;
    cmps++; if (mem_busy !== 1'b0) begin errs++; $display("FAIL ram_wr_busy got %b want 0", mem_busy); end
    nxt; cpu(16'h0010, 1'b0, 16'h0); ram_m[16] = 16'h1234;
    smp;
    cmps++; if (mem_busy !== 1'b0) begin errs++; $display("FAIL ram_rd_busy got %b want 0", mem_busy); end
    nxt; smp;
    cmps++; if (mem_rdata !== old) begin errs++; $display("FAIL ram_read_old got %h want %h", mem_rdata, old); end
    nxt; smp;
    cmps++; if (mem_rdata !== 16'h1234) begin errs++; $display("FAIL ram_rd got %h want 1234", mem_rdata); end
  endtask

  task automatic test_kbd_unmapped;
    kbd_code = 16'h0041;
    nxt; cpu(16'h6000, 1'b0, 16'h0); nxt; nxt; smp;
    cmps++; if (mem_rdata !== 16'h0041) begin errs++; $display("FAIL kbd_rd got %h want 0041", mem_rdata); end
    nxt; cpu(16'h7000, 1'b0, 16'h0); nxt; nxt; smp;
    cmps++; if (mem_rdata !== 16'h0000) begin errs++; $display("FAIL unmapped_rd got %h want 0000", mem_rdata); end
    nxt; cpu(16'h2000, 1'b1, 16'h5A5A); ram_m[8192] = 16'h5A5A;
    nxt; cpu(16'h6000, 1'b1, 16'hBEEF);
    nxt; cpu(16'h6000, 1'b0, 16'h0); nxt; nxt; smp;
    cmps++; if (mem_rdata !== 16'h0041) begin errs++; $display("FAIL kbd_after_wr got %h want 0041", mem_rdata); end
    nxt; cpu(16'h2000, 1'b0, 16'h0); nxt; nxt; smp;
    cmps++; if (mem_rdata !== 16'h5A5A) begin errs++; $display("FAIL kbd_wr_ram_alias got %h want 5a5a", mem_rdata); end
    nxt; cpu(16'h4000, 1'b0, 16'h0); nxt; nxt; smp;
    cmps++; if (mem_rdata !== scr_m[0]) begin errs++; $display("FAIL kbd_wr_scr_alias got %h want %h", mem_rdata, scr_m[0]); end
  endtask

  task automatic test_contention;
    nxt; cpu(16'h0001, 1'b0, 16'h0); vid_req = 1'b0;
    nxt; cpu(16'h4005, 1'b0, 16'h0); vid_req = 1'b1; vid_addr = 13'd3;
    smp;
    cmps++; if (mem_busy !== 1'b1 || vid_ack !== 1'b1) begin errs++; $display("FAIL cont_vid_first got busy=%b ack=%b want 1/1", mem_busy, vid_ack); end
    nxt; vid_addr = 13'd4;
    smp;
    cmps++; if (mem_busy !== 1'b0 || vid_ack !== 1'b0) begin errs++; $display("FAIL cont_cpu_turn got busy=%b ack=%b want 0/0", mem_busy, vid_ack); end
    nxt; cpu(16'h0001, 1'b0, 16'h0);
    smp;
    cmps++; if (vid_ack !== 1'b1) begin errs++; $display("FAIL cont_vid_regrant got %b want 1", vid_ack); end
    cmps++; if (vid_valid !== 1'b1 || vid_rdata !== scr_m[3]) begin errs++; $display("FAIL cont_vid_data got v=%b %h want 1 %h", vid_valid, vid_rdata, scr_m[3]); end
    nxt; vid_req = 1'b0;
    smp;
    cmps++; if (mem_rdata !== scr_m[5]) begin errs++; $display("FAIL cont_cpu_rd got %h want %h", mem_rdata, scr_m[5]); end
    cmps++; if (vid_valid !== 1'b0) begin errs++; $display("FAIL cont_vid_gap got %b want 0", vid_valid); end
    nxt; smp;
    cmps++; if (vid_valid !== 1'b1 || vid_rdata !== scr_m[4]) begin errs++; $display("FAIL cont_vid_data2 got v=%b %h want 1 %h", vid_valid, vid_rdata, scr_m[4]); end
    cmps++; if (mem_rdata !== ram_m[1]) begin errs++; $display("FAIL cont_ram_rd got %h want %h", mem_rdata, ram_m[1]); end
  endtask

  task automatic test_video_stream;
    nxt; cpu(16'h0002, 1'b0, 16'h0); vid_req = 1'b0;
    nxt;
    for (int i = 0; i < 11; i++) begin
      nxt; vid_req = (i < 8); vid_addr = i[12:0];
      smp;
      if (i < 8) begin
        cmps++; if (vid_ack !== 1'b1) begin errs++; $display("FAIL vstream_ack[%0d] got %b want 1", i, vid_ack); end
      end
      if (i >= 2 && i < 10) begin
        cmps++; if (vid_valid !== 1'b1 || vid_rdata !== scr_m[i-2]) begin errs++; $display("FAIL vstream_data[%0d] got v=%b %h want 1 %h", i, vid_valid, vid_rdata, scr_m[i-2]); end
      end else begin
        cmps++; if (vid_valid !== 1'b0) begin errs++; $display("FAIL vstream_idle[%0d] got %b want 0", i, vid_valid); end
      end
    end
    vid_req = 1'b0;
  endtask

  task automatic test_screen_write_under_load;
    int waited = 0;
    nxt; cpu(16'h0003, 1'b0, 16'h0); vid_req = 1'b1; vid_addr = 13'd0;
    nxt; cpu(16'h4000, 1'b1, 16'hFFFF);
    smp;
    while (mem_busy === 1'b1 && waited < 4) begin nxt; waited++; smp; end
    cmps++; if (waited !== 1) begin errs++; $display("FAIL scrwr_wait got %0d want 1", waited); end
    scr_m[0] = 16'hFFFF;
    nxt; cpu(16'h0003, 1'b0, 16'h0);
    smp;
    cmps++; if (vid_ack !== 1'b1) begin errs++; $display("FAIL scrwr_vid_ack got %b want 1", vid_ack); end
    nxt; vid_req = 1'b0;
    nxt; smp;
    cmps++; if (vid_valid !== 1'b1 || vid_rdata !== 16'hFFFF) begin errs++; $display("FAIL scrwr_vid_rd got v=%b %h want 1 ffff", vid_valid, vid_rdata); end
  endtask

  task automatic test_async_reset;
    nxt; cpu(16'h0004, 1'b0, 16'h0); vid_req = 1'b0;
    nxt; cpu(16'h4001, 1'b0, 16'h0); vid_req = 1'b1; vid_addr = 13'd5;
    smp;
    cmps++; if (vid_ack !== 1'b1) begin errs++; $display("FAIL arst_grant got %b want 1", vid_ack); end
    nxt; cpu(16'h0020, 1'b1, 16'hDEAD); vid_addr = 13'd6;
    #1 reset_n = 1'b0;
    #1;
    cmps++; if (vid_ack !== 1'b1) begin errs++; $display("FAIL arst_fsm_idle got ack=%b want 1", vid_ack); end
    cmps++; if (mem_rdata !== 16'h0 || vid_rdata !== 16'h0 || vid_valid !== 1'b0) begin errs++; $display("FAIL arst_outputs got %h %h %b want 0000 0000 0", mem_rdata, vid_rdata, vid_valid); end
    nxt; smp;
    cmps++; if (vid_valid !== 1'b0) begin errs++; $display("FAIL arst_valid_cancel got %b want 0", vid_valid); end
    cpu(16'h0020, 1'b0, 16'h0); vid_req = 1'b0; reset_n = 1'b1;
    nxt; nxt; nxt; smp;
    cmps++; if (mem_rdata !== ram_m[32]) begin errs++; $display("FAIL arst_no_write got %h want %h", mem_rdata, ram_m[32]); end
    nxt; cpu(16'h0010, 1'b0, 16'h0); nxt; nxt; smp;
    cmps++; if (mem_rdata !== 16'h1234) begin errs++; $display("FAIL arst_ram_kept got %h want 1234", mem_rdata); end
  endtask

  task automatic test_random;
    logic lock_m = 1'b0, hold_c = 1'b0, hold_v = 1'b0, known = 1'b0, scr, ack_e, busy_e;
    logic m1v = 1'b0, m2v = 1'b0, v1v = 1'b0, v2v = 1'b0;
    logic [15:0] m1d = '0, m2d = '0, v1d = '0, v2d = '0, exp_rd = '0, a;
    int sel;
    nxt; cpu(16'h0005, 1'b0, 16'h0); vid_req = 1'b0;
    nxt; nxt;
    for (int k = 0; k < 3000; k++) begin
      nxt;
      if (!hold_c) begin
        sel = $urandom_range(0, 9);
        if (sel < 4) a = 16'($urandom_range(0, 63));
        else if (sel < 8) a = 16'h4000 + 16'($urandom_range(0, 31));
        else if (sel == 8) a = 16'h6000;
        else case ($urandom_range(0, 2))
          0: a = 16'h6001;
          1: a = 16'h7ABC;
          default: a = 16'hFFFF;
        endcase
        cpu(a, $urandom_range(0, 2) == 0, 16'($urandom));
      end
      if (!hold_v) begin vid_req = $urandom_range(0, 1) == 1; vid_addr = 13'($urandom_range(0, 31)); end
      kbd_code = 16'($urandom);
      smp;
      scr = mem_address >= 16'h4000 && mem_address < 16'h6000;
      ack_e = vid_req && !lock_m;
      busy_e = scr && ack_e;
      if (m2v) begin exp_rd = m2d; known = 1'b1; end
      cmps++; if (vid_ack !== ack_e) begin errs++; $display("FAIL rnd_ack[%0d] got %b want %b", k, vid_ack, ack_e); end
      cmps++; if (mem_busy !== busy_e) begin errs++; $display("FAIL rnd_busy[%0d] got %b want %b", k, mem_busy, busy_e); end
      cmps++; if (vid_valid !== v2v) begin errs++; $display("FAIL rnd_vvalid[%0d] got %b want %b", k, vid_valid, v2v); end
      if (v2v) begin
        cmps++; if (vid_rdata !== v2d) begin errs++; $display("FAIL rnd_vdata[%0d] got %h want %h", k, vid_rdata, v2d); end
      end
      if (known) begin
        cmps++; if (mem_rdata !== exp_rd) begin errs++; $display("FAIL rnd_rdata[%0d] got %h want %h", k, mem_rdata, exp_rd); end
      end
      m2v = m1v; m2d = m1d; v2v = v1v; v2d = v1d;
      m1v = !busy_e; m1d = model_rd(mem_address, kbd_code);
      v1v = ack_e; v1d = scr_m[vid_addr];
      if (mem_write && !busy_e) begin
        if (mem_address < 16'h4000) ram_m[mem_address[13:0]] = mem_wdata;
        else if (scr) scr_m[mem_address[12:0]] = mem_wdata;
      end
      lock_m = !lock_m && scr;
      hold_c = busy_e;
      hold_v = vid_req && !ack_e;
    end
    vid_req = 1'b0; cpu(16'h0000, 1'b0, 16'h0);
  endtask

  initial begin
    reset_n = 1'b0; cpu(16'h0, 1'b0, 16'h0); vid_req = 1'b0; vid_addr = '0; kbd_code = '0;
    test_reset;
    init_mem;
    test_ram;
    test_kbd_unmapped;
    test_contention;
    test_video_stream;
    test_screen_write_under_load;
    test_async_reset;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end
endmodule
